// File: rtl/excess3_to_bcd_deser.sv
// excess3_to_bcd_deser
//   Serial excess-3 to BCD word assembler. Accepts one excess-3 digit per
//   in_valid/in_ready handshake, most-significant digit first, converts it
//   to BCD (code - 3) and packs DIGITS digits into one word. The completed
//   word is held on a valid/ready output port together with a sticky flag
//   that marks any invalid code seen in that word.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     in_digit holds a digit
//   in_ready     block can accept a digit (COLLECT state)
//   in_digit     excess-3 code
//   flush        synchronous abort of the partial word (ignored in HOLD)
//   out_valid    out_bcd / out_err hold a complete word (HOLD state)
//   out_ready    downstream accepts the word
//   out_bcd      packed BCD, first received digit in the top nibble
//   out_err      at least one digit of the word was an invalid code
//   digit_count  digits collected so far in the current word
module excess3_to_bcd_deser #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_digit,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [2:0]            digit_count
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam logic [2:0]  LAST = 3'(DIGITS - 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t       state, state_next;

  logic [W-1:0] acc;
  logic         err;
  logic         take;
  logic         last;
  logic         code_bad;
  logic [3:0]   nibble;
  logic [W-1:0] acc_shift;

  // Handshake outputs are decoded from state only, so there is no
  // combinational path from any input to any output.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);

  // Decode and pack.
  always_comb begin
    take      = in_valid && in_ready;
    last      = (digit_count == LAST);
    code_bad  = (in_digit < 4'd3) || (in_digit > 4'd12);
    nibble    = code_bad ? 4'hF : (in_digit - 4'd3);
    acc_shift = {acc[W-5:0], nibble};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (take && !flush && last) state_next = HOLD;
      HOLD:    if (out_ready)              state_next = COLLECT;
      default:                             state_next = COLLECT;
    endcase
  end

  // The accumulator is cleared as the finished word is copied to the output
  // register, so it is already empty when HOLD hands back to COLLECT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      err         <= 1'b0;
      digit_count <= '0;
      out_bcd     <= '0;
      out_err     <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (flush) begin
            acc         <= '0;
            err         <= 1'b0;
            digit_count <= '0;
          end else if (take) begin
            if (last) begin
              out_bcd     <= acc_shift;
              out_err     <= err | code_bad;
              acc         <= '0;
              err         <= 1'b0;
              digit_count <= '0;
            end else begin
              acc         <= acc_shift;
              err         <= err | code_bad;
              digit_count <= digit_count + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_bcd <= '0;
            out_err <= 1'b0;
            acc     <= '0;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_deser.sv
module tb_excess3_to_bcd_deser;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_err;
  logic [2:0]  digit_count;

  int tests = 0;
  int fails = 0;

  // Expected words {err, bcd}, pushed as stimulus is driven.
  logic [16:0] exp_q[$];

  excess3_to_bcd_deser #(.DIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_digit    (in_digit),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_err     (out_err),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every output handshake pops and compares one expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_word: got err=%0b bcd=%h, required no word", out_err, out_bcd);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({out_err, out_bcd} !== e) begin
          fails++;
          $display("FAIL sb_word: got err=%0b bcd=%h, required err=%0b bcd=%h",
                   out_err, out_bcd, e[16], e[15:0]);
        end
      end
    end
  end

  // Drive one digit and return 1 ns after the edge that accepts it.
  task automatic send(input logic [3:0] d);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_digit = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_digit = 4'h0; flush = 1'b0; out_ready = 1'b1;
    #2;
    tests++;
    if ({in_ready, out_valid, out_bcd, out_err, digit_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b bcd=%h err=%0b cnt=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, out_bcd, out_err, digit_count);
    end
    #10 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h1590});
    send(4'h4); send(4'h8); send(4'hC); send(4'h3);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency: got vld=%0b rdy=%0b, required 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_one_cycle: got vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_invalid;
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 16'h1F2F});
    send(4'h4); send(4'h0); send(4'h5); send(4'hE);
    exp_q.push_back({1'b0, 16'h0000});
    send(4'h3); send(4'h3); send(4'h3); send(4'h3);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h4321});
    send(4'h7); send(4'h6); send(4'h5); send(4'h4);
    in_digit = 4'h3;  // in_valid stays high: next word's first digit waits
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_bcd !== 16'h4321 || in_ready !== 1'b0 || digit_count !== 3'd0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got vld=%0b bcd=%h rdy=%0b cnt=%0d, required 1 4321 0 0",
                 i, out_valid, out_bcd, in_ready, digit_count);
      end
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b0, 16'h0000});
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b cnt=%0d, required 0 1 0",
               out_valid, in_ready, digit_count);
    end
    @(posedge clk); #1;
    tests++;
    if (digit_count !== 3'd1) begin
      fails++;
      $display("FAIL bp_bubble: got cnt=%0d, required 1", digit_count);
    end
    send(4'h3); send(4'h3); send(4'h3);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    send(4'h9); send(4'hA);
    tests++;
    if (digit_count !== 3'd2) begin
      fails++;
      $display("FAIL flush_pre_count: got %0d, required 2", digit_count);
    end
    in_valid = 1'b1; in_digit = 4'hB; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (digit_count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear: got cnt=%0d vld=%0b, required 0 0", digit_count, out_valid);
    end
    exp_q.push_back({1'b0, 16'h9999});
    send(4'hC); send(4'hC); send(4'hC); send(4'hC);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_gaps;
    logic [3:0] digs [4];
    logic [2:0] cnt_before;
    digs[0] = 4'h5; digs[1] = 4'h6; digs[2] = 4'h7; digs[3] = 4'h8;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h2345});
    for (int i = 0; i < 4; i++) begin
      send(digs[i]);
      in_valid = 1'b0;
      if (i < 3) begin
        cnt_before = digit_count;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        tests++;
        if (digit_count !== cnt_before || digit_count !== 3'(i + 1)) begin
          fails++;
          $display("FAIL gap_count[%0d]: got %0d, required %0d", i, digit_count, i + 1);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    send(4'h5); send(4'h5); send(4'h5);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_bcd, out_err, digit_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_midword: got rdy=%0b vld=%0b bcd=%h err=%0b cnt=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, out_bcd, out_err, digit_count);
    end
    #3 reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 16'h1234});
    send(4'h4); send(4'h5); send(4'h6); send(4'h7);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(4'h0); send(4'h4); send(4'h4); send(4'h4);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_bcd !== 16'hF111) begin
      fails++;
      $display("FAIL hold_before_reset: got vld=%0b err=%0b bcd=%h, required 1 1 f111",
               out_valid, out_err, out_bcd);
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_bcd, out_err, digit_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_hold: got rdy=%0b vld=%0b bcd=%h err=%0b cnt=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, out_bcd, out_err, digit_count);
    end
    #3 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 16'h0909});
    send(4'h3); send(4'hC); send(4'h3); send(4'hC);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_invalid;
    test_backpressure;
    test_flush;
    test_gaps;
    test_async_reset;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
